// File: rtl/sound_sequencer.sv
// sound_sequencer: chooses the note index sent to the buzzer tone generator.
// A background melody loops while enabled. Landing, perfect-landing and
// game-over effects temporarily replace it, with OVER > PERF > LAND > BGM.
// All notes change on a shared tick grid of TICK_CYC clock cycles.
module sound_sequencer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int NOTE_HZ = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_bgm_en,
  input  logic       i_load_done,
  input  logic       i_perfect,
  input  logic       i_gameover,
  output logic [5:0] o_music_scale,
  output logic       o_sfx_active
);

  localparam int TICK_CYC = CLK_HZ / NOTE_HZ;
  localparam int CNT_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYC - 1);

  // Note tables are packed with entry 0 in the least significant slot.
  localparam logic [16*6-1:0] BGM_NOTES = {
    6'd0,  6'd8,  6'd9,  6'd9,  6'd10, 6'd10, 6'd11, 6'd11,
    6'd0,  6'd12, 6'd13, 6'd13, 6'd12, 6'd12, 6'd8,  6'd8
  };
  localparam logic [2*6-1:0] PERF_NOTES = {6'd15, 6'd11};

  // The final OVER entry is the silent hold after the jingle.
  localparam logic [5*6-1:0] OVER_NOTES = {6'd0, 6'd1, 6'd8, 6'd10, 6'd12};
  localparam logic [5:0]     LAND_NOTE  = 6'd4;

  localparam logic [2:0] LAND_LAST = 3'd0;
  localparam logic [2:0] PERF_LAST = 3'd1;
  localparam logic [2:0] OVER_HOLD = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BGM,
    ST_LAND,
    ST_PERF,
    ST_OVER
  } state_t;

  logic [5:0] bgm_rom  [16];
  logic [5:0] perf_rom [2];
  logic [5:0] over_rom [5];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_bgm_rom
      assign bgm_rom[gi] = BGM_NOTES[gi*6 +: 6];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf_rom
      assign perf_rom[gi] = PERF_NOTES[gi*6 +: 6];
    end
    for (genvar gi = 0; gi < 5; gi++) begin : g_over_rom
      assign over_rom[gi] = OVER_NOTES[gi*6 +: 6];
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       sfx_idx_reg, sfx_idx_next;
  logic [3:0]       bgm_idx_reg, bgm_idx_next;
  logic             gameover_q_reg;
  logic [5:0]       music_reg, music_next;
  logic             sfx_active_reg, sfx_active_next;

  logic   tick;
  logic   go_rise;
  logic   effect_req;
  state_t exit_state;

  assign tick       = (cnt_reg == CNT_MAX);
  assign go_rise    = i_gameover & ~gameover_q_reg;
  assign exit_state = i_bgm_en ? ST_BGM : ST_IDLE;

  // A landing is accepted outside OVER and while not game over.
  // A plain landing does not interrupt a perfect-landing effect.
  assign effect_req = i_load_done & ~i_gameover & (state_reg != ST_OVER) &
                      (i_perfect | (state_reg != ST_PERF));

  // Next-state, tick-grid and index logic, including priority between events.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = tick ? '0 : cnt_reg + CNT_W'(1);
    sfx_idx_next = sfx_idx_reg;
    bgm_idx_next = bgm_idx_reg;

    if (go_rise) begin
      state_next   = ST_OVER;
      sfx_idx_next = '0;
      cnt_next     = '0;
    end else if (effect_req) begin
      state_next   = i_perfect ? ST_PERF : ST_LAND;
      sfx_idx_next = '0;
      cnt_next     = '0;
    end else begin
      unique case (state_reg)
        ST_IDLE, ST_BGM: begin
          state_next = exit_state;
          // The melody only advances while it is actually playing.
          if ((state_reg == ST_BGM) && tick && i_bgm_en) begin
            bgm_idx_next = bgm_idx_reg + 4'd1;
          end
        end
        ST_LAND: begin
          if (tick) begin
            if (sfx_idx_reg == LAND_LAST) begin
              state_next   = exit_state;
              sfx_idx_next = '0;
            end else begin
              sfx_idx_next = sfx_idx_reg + 3'd1;
            end
          end
        end
        ST_PERF: begin
          if (tick) begin
            if (sfx_idx_reg == PERF_LAST) begin
              state_next   = exit_state;
              sfx_idx_next = '0;
            end else begin
              sfx_idx_next = sfx_idx_reg + 3'd1;
            end
          end
        end
        ST_OVER: begin
          // The jingle always completes; leaving needs both its end and game over cleared.
          if (!i_gameover && (sfx_idx_reg == OVER_HOLD)) begin
            state_next   = exit_state;
            sfx_idx_next = '0;
          end else if (tick && (sfx_idx_reg != OVER_HOLD)) begin
            sfx_idx_next = sfx_idx_reg + 3'd1;
          end
        end
        default: begin
          state_next   = ST_IDLE;
          sfx_idx_next = '0;
        end
      endcase
    end

    // Disabling the melody rewinds it so re-enabling starts from the top.
    if (!i_bgm_en) begin
      bgm_idx_next = '0;
    end
  end

  // Output lookup uses the next state and index so output follows by exactly one cycle.
  always_comb begin
    music_next      = 6'd0;
    sfx_active_next = 1'b0;
    unique case (state_next)
      ST_BGM: begin
        music_next = bgm_rom[bgm_idx_next];
      end
      ST_LAND: begin
        music_next      = LAND_NOTE;
        sfx_active_next = 1'b1;
      end
      ST_PERF: begin
        music_next      = perf_rom[sfx_idx_next[0]];
        sfx_active_next = 1'b1;
      end
      ST_OVER: begin
        music_next      = (sfx_idx_next <= OVER_HOLD) ? over_rom[sfx_idx_next] : 6'd0;
        sfx_active_next = 1'b1;
      end
      default: begin
        music_next      = 6'd0;
        sfx_active_next = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      sfx_idx_reg    <= '0;
      bgm_idx_reg    <= '0;
      gameover_q_reg <= 1'b0;
      music_reg      <= 6'd0;
      sfx_active_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      sfx_idx_reg    <= sfx_idx_next;
      bgm_idx_reg    <= bgm_idx_next;
      gameover_q_reg <= i_gameover;
      music_reg      <= music_next;
      sfx_active_reg <= sfx_active_next;
    end
  end

  assign o_music_scale = music_reg;
  assign o_sfx_active  = sfx_active_reg;

endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: directed scenarios followed by random traffic.
// DUT outputs are compared each cycle against a note-queue reference model.
module tb_sound_sequencer;

  localparam int CLK_HZ  = 40;
  localparam int NOTE_HZ = 4;
  localparam int T       = CLK_HZ / NOTE_HZ;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bgm_en = 1'b0;
  logic       load_done = 1'b0;
  logic       perfect = 1'b0;
  logic       gameover = 1'b0;
  logic [5:0] music;
  logic       sfx;

  sound_sequencer #(.CLK_HZ(CLK_HZ), .NOTE_HZ(NOTE_HZ)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_bgm_en      (bgm_en),
    .i_load_done   (load_done),
    .i_perfect     (perfect),
    .i_gameover    (gameover),
    .o_music_scale (music),
    .o_sfx_active  (sfx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int melody [16] = '{8, 8, 12, 12, 13, 13, 12, 0, 11, 11, 10, 10, 9, 9, 8, 0};

  // Reference model: cycles into the current note, the active effect
  // (0 none, 1 land, 2 perf, 3 over) with its remaining notes, the melody position.
  int  phase = 0;
  int  fx_kind = 0;
  int  fxq[$];
  int  bidx = 0;
  bit  playing = 0;
  bit  go_prev = 0;
  int  exp_music = 0;
  bit  exp_sfx = 0;

  function automatic void model_step();
    bit tick;
    bit go_rise;
    bit started;
    bit was_done;
    if (rst) begin
      phase   = 0;
      fx_kind = 0;
      fxq.delete();
      bidx    = 0;
      playing = 0;
      go_prev = 0;
    end else begin
      tick    = (phase == T - 1);
      go_rise = gameover && !go_prev;
      started = 0;
      if (go_rise) begin
        fx_kind = 3;
        fxq     = {12, 10, 8, 1};
        started = 1;
      end else if (load_done && !gameover && fx_kind != 3) begin
        if (perfect) begin
          fx_kind = 2;
          fxq     = {11, 15};
          started = 1;
        end else if (fx_kind != 2) begin
          fx_kind = 1;
          fxq     = {4};
          started = 1;
        end
      end
      if (started) begin
        phase = 0;
      end else begin
        phase = tick ? 0 : phase + 1;
        if (fx_kind == 1 || fx_kind == 2) begin
          if (tick) begin
            void'(fxq.pop_front());
            if (fxq.size() == 0) fx_kind = 0;
          end
        end else if (fx_kind == 3) begin
          was_done = (fxq.size() == 0);
          if (!gameover && was_done) fx_kind = 0;
          else if (tick && !was_done) void'(fxq.pop_front());
        end else begin
          if (playing && bgm_en && tick) bidx = (bidx + 1) % 16;
        end
      end
      if (!bgm_en) bidx = 0;
      if (fx_kind == 0) playing = bgm_en;
      go_prev = gameover;
    end
    if (fx_kind != 0) begin
      exp_sfx   = 1;
      exp_music = (fxq.size() > 0) ? fxq[0] : 0;
    end else begin
      exp_sfx   = 0;
      exp_music = playing ? melody[bidx] : 0;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    checks++;
    assert (music === 6'(exp_music)) else begin
      errors++;
      $error("FAIL music_scale: got %0d expected %0d at %0t", music, exp_music, $time);
    end
    checks++;
    assert (sfx === exp_sfx) else begin
      errors++;
      $error("FAIL sfx_active: got %0b expected %0b at %0t", sfx, exp_sfx, $time);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_load(input bit p);
    load_done = 1'b1;
    perfect   = p;
    cyc();
    load_done = 1'b0;
    perfect   = 1'b0;
  endtask

  // Wait (bounded) until the model reaches the requested melody note, mid-note.
  task automatic wait_bgm(input int idx);
    int n = 0;
    while (!(fx_kind == 0 && playing && bidx == idx && phase == 4) && n <= 400) begin
      cyc();
      n++;
    end
    checks++;
    assert (n <= 400) else begin
      errors++;
      $error("FAIL wait_bgm_idx: got idx %0d expected %0d", bidx, idx);
    end
  endtask

  // Wait (bounded) until the perfect-landing effect is on its second note, mid-note.
  task automatic wait_perf_second();
    int n = 0;
    while (!(fx_kind == 2 && fxq.size() == 1 && phase == 3) && n <= 100) begin
      cyc();
      n++;
    end
    checks++;
    assert (n <= 100) else begin
      errors++;
      $error("FAIL wait_perf_note2: got fx %0d expected 2", fx_kind);
    end
  endtask

  initial begin
    // 1: reset then melody
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    bgm_en = 1'b1;
    run(170);
    $display("step 1 bgm loop: checks=%0d errors=%0d", checks, errors);

    // 2: landing during note index 5
    wait_bgm(5);
    pulse_load(1'b0);
    run(30);
    $display("step 2 land over bgm: checks=%0d errors=%0d", checks, errors);

    // 3: perfect landing, plain landing dropped, perfect restarts
    pulse_load(1'b1);
    wait_perf_second();
    pulse_load(1'b0);
    run(3);
    pulse_load(1'b1);
    run(25);
    $display("step 3 perf priority: checks=%0d errors=%0d", checks, errors);

    // 4: game over mid-land together with a landing pulse
    pulse_load(1'b0);
    run(4);
    gameover  = 1'b1;
    load_done = 1'b1;
    cyc();
    load_done = 1'b0;
    run(15);
    pulse_load(1'b1);
    run(50);
    gameover = 1'b0;
    run(30);
    $display("step 4 game over: checks=%0d errors=%0d", checks, errors);

    // 5: disable and re-enable the melody
    wait_bgm(3);
    bgm_en = 1'b0;
    cyc();
    bgm_en = 1'b1;
    run(20);
    $display("step 5 bgm disable: checks=%0d errors=%0d", checks, errors);

    // 6: reset during OVER with game over still asserted
    gameover = 1'b1;
    run(15);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    run(20);
    gameover = 1'b0;
    run(50);
    $display("step 6 reset mid-over: checks=%0d errors=%0d", checks, errors);

    // 7: random traffic
    for (int i = 0; i < 3000; i++) begin
      load_done = ($urandom_range(0, 11) == 0);
      perfect   = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 149) == 0) gameover = ~gameover;
      if ($urandom_range(0, 199) == 0) bgm_en = ~bgm_en;
      rst = ($urandom_range(0, 999) == 0);
      cyc();
    end
    rst = 1'b0;
    load_done = 1'b0;
    $display("step 7 random: checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
